// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_MUL_WAIT = 2'd1;
  localparam state_t ST_DIV_ITER = 2'd2;
  localparam state_t ST_DONE     = 2'd3;

  localparam int unsigned DIV_ITERATIONS = 32;
  localparam int unsigned CNT_W          = 5;
  localparam int unsigned REM_W          = 33;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // Two's complement negation mod 2^32; INT_MIN maps to itself.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'(~v + 32'd1);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module muldiv_div_step
  import muldiv_pkg::*;
(
  input  logic [REM_W-1:0] rem_i,
  input  logic             in_bit_i,
  input  logic [31:0]      divisor_i,
  output logic [REM_W-1:0] rem_o,
  output logic             q_bit_o
);

  logic [REM_W:0] trial;
  logic [REM_W:0] diff;

  always_comb begin
    trial   = {rem_i, in_bit_i};
    diff    = trial - {2'b00, divisor_i};
    // No borrow out of the top bit means the divisor fit.
    q_bit_o = ~diff[REM_W];
    rem_o   = q_bit_o ? diff[REM_W-1:0] : trial[REM_W-1:0];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer for the EX stage; stalls the pipe while busy.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      prod_q, prod_d;
  logic [31:0]      quo_q, quo_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [1:0]       op_q, op_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [31:0]      result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             a_sext, b_sext, div_signed;
  logic [63:0]      a_ext, b_ext, mul_full;
  logic             a_neg, b_neg, div_zero, div_ovf;
  logic [31:0]      abs_a, abs_b;
  logic [REM_W-1:0] rem_step;
  logic             q_bit;
  logic [31:0]      quo_step, quo_fin, rem_fin;

  muldiv_div_step u_div_step (
    .rem_i     (rem_q),
    .in_bit_i  (quo_q[31]),
    .divisor_i (dvs_q),
    .rem_o     (rem_step),
    .q_bit_o   (q_bit)
  );

  // Operand conditioning for acceptance in IDLE.
  always_comb begin
    a_sext     = (funct3 != OP_MULHU);
    b_sext     = (funct3 == OP_MUL) || (funct3 == OP_MULH);
    a_ext      = {{32{a_sext & rs1_val[31]}}, rs1_val};
    b_ext      = {{32{b_sext & rs2_val[31]}}, rs2_val};
    mul_full   = a_ext * b_ext;
    div_signed = (funct3 == OP_DIV) || (funct3 == OP_REM);
    a_neg      = div_signed & rs1_val[31];
    b_neg      = div_signed & rs2_val[31];
    abs_a      = a_neg ? neg32(rs1_val) : rs1_val;
    abs_b      = b_neg ? neg32(rs2_val) : rs2_val;
    div_zero   = (rs2_val == 32'd0);
    div_ovf    = div_signed && (rs1_val == INT_MIN) && (rs2_val == 32'hFFFF_FFFF);
    quo_step   = {quo_q[30:0], q_bit};
    quo_fin    = qneg_q ? neg32(quo_step) : quo_step;
    rem_fin    = rneg_q ? neg32(rem_step[31:0]) : rem_step[31:0];
  end

  always_comb begin
    accept = (state_q == ST_IDLE) && start && !kill;
    stall  = accept ||
             (((state_q == ST_MUL_WAIT) || (state_q == ST_DIV_ITER)) && !kill);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = funct3[1:0];
          if (!funct3[2]) begin
            prod_d  = mul_full;
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
            state_d = ST_MUL_WAIT;
          end else if (div_zero) begin
            result_d = funct3[1] ? rs1_val : DIV0_QUOTIENT;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? 32'd0 : INT_MIN;
            state_d  = ST_DONE;
          end else begin
            quo_d   = abs_a;
            rem_d   = '0;
            dvs_d   = abs_b;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = CNT_W'(DIV_ITERATIONS - 1);
            state_d = ST_DIV_ITER;
          end
        end
      end
      ST_MUL_WAIT: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          result_d = (op_q == 2'b00) ? prod_q[31:0] : prod_q[63:32];
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV_ITER: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          quo_d = quo_step;
          rem_d = rem_step;
          if (cnt_q == '0) begin
            result_d = op_q[1] ? rem_fin : quo_fin;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, multi-cycle corner sequences, random vs. model.
module tb_muldiv_sequencer;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned NVEC    = 16;
  localparam int unsigned NRAND   = 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_val = 32'd0;
  logic [31:0] rs2_val = 32'd0;
  logic        stall, busy, done;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [NVEC];

  muldiv_sequencer #(.MUL_LATENCY(MUL_LAT), .XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .kill    (kill),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else passed++;
  endtask

  // Architectural RV32M result, straight from the ISA definition.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, ps;
    longint unsigned pu;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = int'(a);
    ib = int'(b);
    case (f3)
      3'd0: begin ps = sa * sb; return ps[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * ub; return ps[63:32]; end
      3'd3: begin pu = 64'(ua) * 64'(ub); return pu[63:32]; end
      default: begin
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
          return f3[1] ? 32'(ia % ib) : 32'(ia / ib);
        end
        return f3[1] ? (a % b) : (a / b);
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return int'(MUL_LAT) + 1;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at a negedge in IDLE; returns at a negedge in the IDLE cycle after DONE.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  k;
    bit  stall_ok;
    start   = 1'b1;
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    #1;
    chk({name, "_stall_accept"}, 32'(stall), 32'd1);
    @(negedge clk);
    start   = 1'b0;
    funct3  = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    k = 1;
    stall_ok = 1'b1;
    while (!done && k <= 40) begin
      if (!stall || !busy) stall_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, 32'(k), 32'(lat));
    chk({name, "_result"}, result, exp);
    chk({name, "_stall_busy_run"}, 32'(stall_ok), 32'd1);
    chk({name, "_stall_done"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          mode;
    bit          no_done;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 4};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 4};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4};
    vecs[3]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 4};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'd4, 32'h8000_0000,  32'd2,         32'hC000_0000, 33};
    vecs[13] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};
    vecs[14] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};

    #12;
    chk("reset_outputs", {28'd0, stall, busy, done, 1'b0}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // kill in IDLE blocks acceptance
    start = 1'b1; kill = 1'b1; funct3 = 3'd5; rs1_val = 32'd9; rs2_val = 32'd3;
    #1;
    chk("kill_idle_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("kill_idle_busy", 32'(busy), 32'd0);
    start = 1'b0; kill = 1'b0;
    @(negedge clk);

    for (int i = 0; i < int'(NVEC); i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // kill mid-division at T+10, restart at T+11
    start = 1'b1; funct3 = 3'd5; rs1_val = 32'd100; rs2_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    no_done = 1'b1;
    repeat (9) begin
      if (done) no_done = 1'b0;
      @(negedge clk);
    end
    kill = 1'b1;
    #1;
    chk("kill_stall_drop", 32'(stall), 32'd0);
    @(negedge clk);
    kill = 1'b0;
    chk("kill_no_done", 32'({no_done, done}), 32'd2);
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_result_held", result, vecs[NVEC-1].exp);
    run_op("after_kill", 3'd5, 32'd9, 32'd3, 32'd3, 33);

    // asynchronous reset mid-division
    start = 1'b1; funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_flags", {29'd0, stall, busy, done}, 32'd0);
    chk("areset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("areset_idle", {30'd0, busy, done}, 32'd0);

    // back-to-back MULs with start held through DONE
    start = 1'b1; funct3 = 3'd0; rs1_val = 32'd7; rs2_val = 32'hFFFF_FFFD;
    repeat (4) @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_result1", result, 32'hFFFF_FFEB);
    chk("b2b_stall_in_done", 32'(stall), 32'd0);
    funct3 = 3'd3; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("b2b_accept2", {30'd0, busy, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_result2", result, 32'hFFFF_FFFE);
    @(negedge clk);

    // randomized operations against the reference model
    for (int i = 0; i < int'(NRAND); i++) begin
      f3   = 3'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'($urandom_range(1, 16)) | (b & 32'h8000_0000);
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b), ref_lat(f3, a, b));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller and datapath for the RV32M instructions (opcode 0110011, funct7 0000001) in the pipelined core's EX stage.
- Accepts one operation from EX and stalls the pipeline while it runs.
- Multiply completes after a fixed parameterised latency; divide/remainder uses a 32-iteration restoring divider.
- Returns the 32-bit result with a one-cycle done pulse.
- Hazard unit ORs `stall` into its stall logic; `kill` comes from the branch-flush path.

Parameters:
- MUL_LATENCY, 3, cycles spent in MUL_WAIT (legal range 1..8).
- XLEN, 32, operand/result width (only 32 supported).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds an M-extension instruction.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  32  operand A (dividend).
- rs2_val  in  32  operand B (divisor).
- kill  in  1  flush of the EX instruction; aborts any operation.
- stall  out  1  freeze IF/ID/EX.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  selected result, held until the next acceptance.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk and rst_n as named above.
  - Reset: state=IDLE, cnt=0, result=0, done=0, busy=0, stall=0.
  - Reset mid-operation discards the operation with no done.
- States: IDLE, MUL_WAIT, DIV_ITER, DONE. Encoding is in the package.
- Acceptance: in IDLE with start=1 and kill=0, in cycle T.
  - Operands and funct3 are latched at T; EX need not hold them afterwards.
- stall (combinational) = (IDLE & start & !kill) | MUL_WAIT | DIV_ITER. stall is low in DONE.
- IDLE → MUL_WAIT on an accepted funct3[2]=0.
  - Full 64-bit product is registered at T, using signed/unsigned operand extension per funct3.
  - cnt = MUL_LATENCY-1.
- MUL_WAIT: if cnt==0 go to DONE, else decrement cnt. done is asserted at T+MUL_LATENCY+1.
- Result selection: MUL = product[31:0]; MULH, MULHSU, MULHU = product[63:32].
- IDLE → DONE on a divide special case (done at T+1):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend (signed and unsigned).
  - Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- IDLE → DIV_ITER otherwise.
  - Magnitudes are taken (abs for signed ops); cnt = 31.
- DIV_ITER: one restoring step per cycle, MSB first.
  - When cnt==0: sign-correct and go to DONE, so done is at T+33.
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
- DONE: done=1 for exactly one cycle, result is valid, next state is IDLE.
  - A start seen during DONE is not accepted; it is accepted in the following IDLE cycle.
- kill: in any non-IDLE state, the next state is IDLE.
  - No done pulse; result is unchanged; stall drops combinationally in the killing cycle.
  - kill in IDLE blocks acceptance.
  - kill in DONE still completes (done=1 is already asserted; the pipeline discards it).
- result updates only on the DONE entry edge and holds otherwise.
- Width rules:
  - Remainder register is 33 bits during iteration.
  - Negation is two's complement mod 2^32.
  - abs(0x80000000) = 0x80000000, treated as unsigned.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 op enum.
  - state enum.
  - DIV_ITERATIONS=32.
  - DIV0_QUOTIENT=32'hFFFFFFFF.
  - INT_MIN=32'h80000000.
- One sub-module, muldiv_div_step: combinational single restoring step.
  - Inputs: {rem, quotient bit shift, divisor}.
  - Outputs: next rem, next quotient bit.
- The FSM, counter and mul register remain in muldiv_sequencer.

Test Plan:
- MUL 7 × 0xFFFFFFFD accepted at T → stall high T..T+3; done at T+4; result 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD, done at T+33. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF at T+1. REM 5/0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0. Each in one cycle.
- Division accepted at T, kill at T+10 → IDLE at T+11, no done, busy=0, result unchanged. A new DIVU 9/3 started at T+11 → 3 at T+44.
- rst_n low at T+5 of a division → all outputs 0 immediately (asynchronous). Back-to-back MUL ops with start held through DONE → second operation accepted the cycle after the first done.
